// File: rtl/sdf_pkg.sv
// Shared types and constants for the 32-point radix-2 SDF butterfly stage.
package sdf_pkg;
  localparam int DW   = 24;
  localparam int FRAC = 8;
  localparam int N    = 32;
  localparam int HALF = 16;

  localparam logic [4:0] CNT_HALF_LAST = 5'(HALF - 1);
  localparam logic [4:0] CNT_LAST      = 5'(N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    BFLY  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } cplx_t;
endpackage

// File: rtl/sdf_delay_line.sv
// Shift-register delay line holding half a frame of complex samples.
module sdf_delay_line import sdf_pkg::*; #(
  parameter int W     = 48,
  parameter int DEPTH = HALF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         shift_en,
  input  logic [W-1:0] din,
  output logic [W-1:0] head
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (shift_en) begin
      mem[0] <= din;
      for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
    end
  end

  assign head = mem[DEPTH-1];

endmodule

// File: rtl/sdf_bf_stage16.sv
// Radix-2 single-path delay-feedback stage: 16-deep feedback delay, butterfly,
// and twiddle multiply on the fed-back differences. Result registered once.
module sdf_bf_stage16 import sdf_pkg::*; #(
  parameter int DW   = 24,
  parameter int FRAC = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic signed [DW-1:0] din_r,
  input  logic signed [DW-1:0] din_i,
  input  logic                 in_valid,
  output logic [3:0]           tw_idx,
  input  logic signed [DW-1:0] w_r,
  input  logic signed [DW-1:0] w_i,
  output logic signed [DW-1:0] dout_r,
  output logic signed [DW-1:0] dout_i,
  output logic                 out_valid,
  output logic                 proto_err,
  output state_t               dbg_state
);

  localparam int PW = 2 * DW;

  // in_valid/out_valid: no backpressure; a frame is 32 consecutive in_valid
  // cycles and out_valid marks each cycle dout carries a sum or twiddled diff.
  state_t state, state_nxt;
  logic [4:0] cnt, cnt_nxt;
  logic pend, pend_nxt, err_nxt, vld_nxt, shift_en;
  logic [PW-1:0] dl_in, dl_head;
  logic signed [DW-1:0] a_r, a_i, b_r, b_i, res_r, res_i;
  logic signed [DW-1:0] sum_r, sum_i, dif_r, dif_i, mul_r, mul_i;
  logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;

  sdf_delay_line #(.W(PW), .DEPTH(HALF)) u_dl (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (shift_en),
    .din      (dl_in),
    .head     (dl_head)
  );

  assign a_r = dl_head[PW-1:DW];
  assign a_i = dl_head[DW-1:0];
  // A missing sample is replaced by zero so the frame keeps its timing.
  assign b_r = in_valid ? din_r : '0;
  assign b_i = in_valid ? din_i : '0;

  assign sum_r = a_r + b_r;
  assign sum_i = a_i + b_i;
  assign dif_r = a_r - b_r;
  assign dif_i = a_i - b_i;

  assign p_rr  = PW'(a_r) * PW'(w_r);
  assign p_ii  = PW'(a_i) * PW'(w_i);
  assign p_ri  = PW'(a_r) * PW'(w_i);
  assign p_ir  = PW'(a_i) * PW'(w_r);
  assign mul_r = DW'((p_rr - p_ii) >>> FRAC);
  assign mul_i = DW'((p_ri + p_ir) >>> FRAC);

  assign tw_idx    = cnt[3:0];
  assign dbg_state = state;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pend_nxt  = pend;
    err_nxt   = proto_err;
    vld_nxt   = 1'b0;
    shift_en  = 1'b0;
    dl_in     = '0;
    res_r     = '0;
    res_i     = '0;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          shift_en  = 1'b1;
          dl_in     = {din_r, din_i};
          cnt_nxt   = 5'd1;
          state_nxt = FILL;
        end
      end
      FILL: begin
        shift_en = 1'b1;
        cnt_nxt  = cnt + 5'd1;
        if (pend) begin
          vld_nxt = 1'b1;
          res_r   = mul_r;
          res_i   = mul_i;
        end
        if (pend && cnt == 5'd0 && !in_valid) begin
          // Stream ended at a frame boundary: drain the stored diffs.
          state_nxt = FLUSH;
        end else begin
          dl_in = {b_r, b_i};
          if (!in_valid) err_nxt = 1'b1;
          if (cnt == CNT_HALF_LAST) begin
            state_nxt = BFLY;
            pend_nxt  = 1'b0;
          end
        end
      end
      BFLY: begin
        shift_en = 1'b1;
        dl_in    = {dif_r, dif_i};
        vld_nxt  = 1'b1;
        res_r    = sum_r;
        res_i    = sum_i;
        cnt_nxt  = cnt + 5'd1;
        if (!in_valid) err_nxt = 1'b1;
        if (cnt == CNT_LAST) begin
          state_nxt = FILL;
          pend_nxt  = 1'b1;
        end
      end
      FLUSH: begin
        shift_en = 1'b1;
        vld_nxt  = 1'b1;
        res_r    = mul_r;
        res_i    = mul_i;
        cnt_nxt  = cnt + 5'd1;
        if (in_valid) err_nxt = 1'b1;
        if (cnt == CNT_HALF_LAST) begin
          state_nxt = IDLE;
          pend_nxt  = 1'b0;
          cnt_nxt   = 5'd0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      pend      <= 1'b0;
      proto_err <= 1'b0;
      out_valid <= 1'b0;
      dout_r    <= '0;
      dout_i    <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      pend      <= pend_nxt;
      proto_err <= err_nxt;
      out_valid <= vld_nxt;
      dout_r    <= res_r;
      dout_i    <= res_i;
    end
  end

endmodule

// File: tb/tb_sdf_bf_stage16.sv
// Bench for sdf_bf_stage16: frame-level reference model (pairwise sums, twiddled
// differences) feeding an expected queue, checked cycle by cycle.
module tb_sdf_bf_stage16;
  import sdf_pkg::*;

  localparam int MAXC = 100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic signed [DW-1:0] din_r, din_i, w_r, w_i, dout_r, dout_i;
  logic in_valid, out_valid, proto_err;
  logic [3:0] tw_idx;
  state_t dbg_state;

  int checks = 0;
  int errors = 0;

  // clock / reset
  always #5 clk = ~clk;

  sdf_bf_stage16 #(.DW(DW), .FRAC(FRAC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din_r     (din_r),
    .din_i     (din_i),
    .in_valid  (in_valid),
    .tw_idx    (tw_idx),
    .w_r       (w_r),
    .w_i       (w_i),
    .dout_r    (dout_r),
    .dout_i    (dout_i),
    .out_valid (out_valid),
    .proto_err (proto_err),
    .dbg_state (dbg_state)
  );

  // twiddle ROM seen by the DUT
  logic signed [DW-1:0] tw_r [16];
  logic signed [DW-1:0] tw_i [16];
  assign w_r = tw_r[tw_idx];
  assign w_i = tw_i[tw_idx];

  // frame data, stimulus and scoreboard
  logic signed [DW-1:0] fr_r [2][32];
  logic signed [DW-1:0] fr_i [2][32];
  bit                   st_v [MAXC];
  logic signed [DW-1:0] st_r [MAXC];
  logic signed [DW-1:0] st_i [MAXC];
  bit                   exp_v [MAXC];
  logic [2*DW-1:0]      exp_q [$];
  int nfr, vcount, streak, max_streak;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic signed [DW-1:0] rnd_dw();
    logic [31:0] v;
    v = $urandom();
    return v[DW-1:0];
  endfunction

  function automatic logic signed [DW-1:0] rnd_tw();
    int v;
    v = int'($urandom_range(512)) - 256;
    return v[DW-1:0];
  endfunction

  function automatic cplx_t cmul(input logic signed [DW-1:0] dr, di, wr, wi);
    longint re, im;
    cplx_t r;
    re = (longint'(dr) * longint'(wr) - longint'(di) * longint'(wi)) >>> FRAC;
    im = (longint'(dr) * longint'(wi) + longint'(di) * longint'(wr)) >>> FRAC;
    r.re = re[DW-1:0];
    r.im = im[DW-1:0];
    return r;
  endfunction

  task automatic rand_tw();
    for (int k = 0; k < 16; k++) begin
      tw_r[k] = rnd_tw();
      tw_i[k] = rnd_tw();
    end
  endtask

  task automatic rand_frame(input int f);
    for (int n = 0; n < 32; n++) begin
      fr_r[f][n] = rnd_dw();
      fr_i[f][n] = rnd_dw();
    end
  endtask

  // Frame f starting at cycle 32f: sum j appears after edge 32f+16+j,
  // twiddled diff j after edge 32f+32+j.
  task automatic prep();
    exp_q.delete();
    for (int c = 0; c < MAXC; c++) begin
      exp_v[c] = 1'b0;
      st_v[c]  = (c < 32 * nfr);
      st_r[c]  = (c < 32 * nfr) ? fr_r[c/32][c%32] : '0;
      st_i[c]  = (c < 32 * nfr) ? fr_i[c/32][c%32] : '0;
    end
    for (int f = 0; f < nfr; f++) begin
      for (int j = 0; j < 16; j++) begin
        int sr, si;
        sr = int'(fr_r[f][j]) + int'(fr_r[f][j+16]);
        si = int'(fr_i[f][j]) + int'(fr_i[f][j+16]);
        exp_v[32*f+16+j] = 1'b1;
        exp_q.push_back({sr[DW-1:0], si[DW-1:0]});
      end
      for (int j = 0; j < 16; j++) begin
        int dr, di;
        dr = int'(fr_r[f][j]) - int'(fr_r[f][j+16]);
        di = int'(fr_i[f][j]) - int'(fr_i[f][j+16]);
        exp_v[32*f+32+j] = 1'b1;
        exp_q.push_back(cmul(dr[DW-1:0], di[DW-1:0], tw_r[j], tw_i[j]));
      end
    end
    vcount = 0; streak = 0; max_streak = 0;
  endtask

  // driver + per-cycle scoreboard check
  task automatic run(input int c0, input int c1);
    logic [2*DW-1:0] e;
    int nc;
    for (int c = c0; c < c1; c++) begin
      in_valid = st_v[c];
      din_r    = st_r[c];
      din_i    = st_i[c];
      @(posedge clk);
      #1;
      chk($sformatf("out_valid@%0d", c), 64'(out_valid), 64'(exp_v[c]));
      if (out_valid) begin
        vcount++; streak++;
        if (streak > max_streak) max_streak = streak;
      end else streak = 0;
      if (exp_v[c]) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        chk($sformatf("dout@%0d", c), 64'({dout_r, dout_i}), 64'(e));
      end
      nc = c + 1;
      chk($sformatf("tw_idx@%0d", c), 64'(tw_idx),
          64'((nc < 32 * nfr + 16) ? (nc % 16) : 0));
    end
    in_valid = 1'b0;
    din_r    = '0;
    din_i    = '0;
  endtask

  task automatic reset_dut();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_dout", 64'({dout_r, dout_i}), 64'(0));
    chk("rst_proto_err", 64'(proto_err), 64'(0));
    chk("rst_tw_idx", 64'(tw_idx), 64'(0));
    chk("rst_state", 64'(dbg_state), 64'(IDLE));
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    in_valid = 1'b0;
    din_r = '0;
    din_i = '0;
    for (int k = 0; k < 16; k++) begin tw_r[k] = DW'(256); tw_i[k] = '0; end
    #2;
    reset_dut();

    // ramp frame
    rand_tw();
    tw_r[0] = DW'(256); tw_i[0] = '0;
    tw_r[8] = '0;       tw_i[8] = DW'(-256);
    nfr = 1;
    for (int n = 0; n < 32; n++) begin fr_r[0][n] = DW'(n); fr_i[0][n] = '0; end
    prep();
    run(0, 52);
    chk("ramp_err", 64'(proto_err), 64'(0));
    chk("ramp_idle", 64'(dbg_state), 64'(IDLE));

    // DC frame: valid for exactly 32 cycles
    rand_tw();
    for (int n = 0; n < 32; n++) begin fr_r[0][n] = DW'(100); fr_i[0][n] = '0; end
    prep();
    run(0, 52);
    chk("dc_valid_count", 64'(vcount), 64'(32));

    // truncation of negative products
    rand_tw();
    tw_r[1] = DW'(251); tw_i[1] = DW'(-50);
    for (int n = 0; n < 32; n++) begin fr_r[0][n] = '0; fr_i[0][n] = '0; end
    fr_r[0][1] = DW'(1);
    prep();
    run(0, 52);

    // two back-to-back random frames, full-range data exercises wrap
    rand_tw();
    nfr = 2;
    rand_frame(0);
    rand_frame(1);
    prep();
    run(0, 84);
    chk("b2b_streak", 64'(max_streak), 64'(64));
    chk("b2b_valid_count", 64'(vcount), 64'(64));
    chk("b2b_err", 64'(proto_err), 64'(0));

    // reset mid-frame, then a fresh frame
    nfr = 1;
    rand_tw();
    rand_frame(0);
    prep();
    run(0, 20);
    reset_dut();
    rand_frame(0);
    prep();
    run(0, 52);
    chk("post_rst_idle", 64'(dbg_state), 64'(IDLE));

    // in_valid dropped at t=5: zero substituted, sticky error
    rand_tw();
    rand_frame(0);
    fr_r[0][5] = '0; fr_i[0][5] = '0;
    prep();
    st_v[5] = 1'b0;
    st_r[5] = rnd_dw();
    st_i[5] = rnd_dw();
    run(0, 5);
    chk("drop_err_before", 64'(proto_err), 64'(0));
    run(5, 6);
    chk("drop_err_set", 64'(proto_err), 64'(1));
    run(6, 52);
    repeat (3) @(posedge clk);
    #1;
    chk("drop_err_held", 64'(proto_err), 64'(1));
    chk("drop_idle", 64'(dbg_state), 64'(IDLE));
    reset_dut();

    // in_valid during flush: ignored, sets error
    rand_tw();
    rand_frame(0);
    prep();
    st_v[36] = 1'b1;
    st_r[36] = rnd_dw();
    st_i[36] = rnd_dw();
    run(0, 36);
    chk("flush_err_before", 64'(proto_err), 64'(0));
    run(36, 37);
    chk("flush_err_set", 64'(proto_err), 64'(1));
    run(37, 52);
    chk("flush_idle", 64'(dbg_state), 64'(IDLE));
    chk("flush_queue_empty", 64'(exp_q.size()), 64'(0));

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
